// File: rtl/ui_pkg.sv
// Shared user-interface definitions: push-button FSM states and default
// timing constants used by the button conditioner and the sequencer top.
package ui_pkg;

    localparam int DEBOUNCE_CYCLES_DEF   = 10;
    localparam int LONG_PRESS_CYCLES_DEF = 100;
    localparam int SYNC_STAGES_DEF       = 2;

    typedef enum logic [1:0] {
        IDLE             = 2'd0,
        PRESS_DEBOUNCE   = 2'd1,
        HELD             = 2'd2,
        RELEASE_DEBOUNCE = 2'd3
    } btn_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous pad bit. Shared by all
// pad inputs that need to be brought into the clk domain.
module bit_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    // Shift the pad level through the flop chain; all stages clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: synchronise, debounce both edges, and emit
// single-cycle press / release / long-press strobes plus a clean level.
//
// state            | meaning
// -----------------+-------------------------------------------------------
// IDLE             | button released and stable
// PRESS_DEBOUNCE   | sync high, counting stable cycles before accepting press
// HELD             | press accepted, hold counter running
// RELEASE_DEBOUNCE | sync low, counting stable cycles before accepting release
module button_conditioner
    import ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
    parameter int SYNC_STAGES       = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

    logic              sync;
    btn_state_e        state, state_next;
    logic [DB_W-1:0]   db_cnt, db_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic              press_next, release_next, long_next, pressed_next;
    logic              active_now, active_next;

    bit_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (button_raw),
        .q    (sync)
    );

    // Next-state, counter and strobe decode for the debounce FSM.
    always_comb begin
        state_next   = state;
        db_next      = db_cnt;
        hold_next    = hold_cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;

        case (state)
            IDLE: begin
                if (sync) begin
                    state_next = PRESS_DEBOUNCE;
                    db_next    = '0;
                end
            end
            PRESS_DEBOUNCE: begin
                if (!sync) begin
                    state_next = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_next = HELD;
                    press_next = 1'b1;
                    hold_next  = '0;
                end else begin
                    db_next = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (hold_cnt != HOLD_MAX) hold_next = hold_cnt + 1'b1;
                if (!sync) begin
                    state_next = RELEASE_DEBOUNCE;
                    db_next    = '0;
                end
            end
            RELEASE_DEBOUNCE: begin
                if (hold_cnt != HOLD_MAX) hold_next = hold_cnt + 1'b1;
                if (sync) begin
                    state_next = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end else begin
                    db_next = db_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        active_now   = (state == HELD) || (state == RELEASE_DEBOUNCE);
        active_next  = (state_next == HELD) || (state_next == RELEASE_DEBOUNCE);
        pressed_next = active_next;
        // Long press only fires while the press is still live after this edge,
        // which keeps it from coinciding with the release strobe.
        if (active_now && active_next && (hold_cnt == HOLD_LAST)) long_next = 1'b1;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            db_cnt           <= '0;
            hold_cnt         <= '0;
            pressed          <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            state            <= state_next;
            db_cnt           <= db_next;
            hold_cnt         <= hold_next;
            pressed          <= pressed_next;
            press_pulse      <= press_next;
            release_pulse    <= release_next;
            long_press_pulse <= long_next;
        end
    end

endmodule
